// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller in front of a combinational 16-bit ALU: accepts one op,
// iterates 1-bit shifts for arbitrary shift amounts, and returns result + flags.
module alu_op_sequencer #(
  parameter int MAX_SHIFT  = 16,
  parameter int SHAMT_BITS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [5:0]  alu_instruction,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_neg,
  output logic        rsp_write,
  output logic        rsp_illegal
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  localparam logic [5:0] OP_MOVE   = 6'd3;
  localparam logic [5:0] OP_SHIFTR = 6'd7;
  localparam logic [5:0] OP_SHIFTL = 6'd8;
  localparam logic [5:0] OP_TEST   = 6'd11;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [5:0]            op_q;
  logic [15:0]           acc;
  logic [15:0]           b_q;
  logic [CNT_W-1:0]      cnt;
  logic [SHAMT_BITS-1:0] shamt;
  logic [CNT_W-1:0]      shamt_sat;
  logic                  req_legal;
  logic                  req_shift;
  logic                  accept;
  logic                  load_en;
  logic [15:0]           load_val;

  assign shamt     = req_b[SHAMT_BITS-1:0];
  assign req_legal = (req_op >= 6'd3) && (req_op <= 6'd11);
  assign req_shift = (req_op == OP_SHIFTR) || (req_op == OP_SHIFTL);
  assign accept    = (state == IDLE) && req_valid;

  always_comb begin
    if (32'(shamt) > MAX_SHIFT) shamt_sat = CNT_W'(MAX_SHIFT);
    else                        shamt_sat = CNT_W'(shamt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // The ALU sees MOVE whenever no operation is being evaluated on it.
  always_comb begin
    next_state      = state;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    alu_instruction = OP_MOVE;
    alu_a           = acc;
    alu_b           = b_q;
    load_en         = 1'b0;
    load_val        = 16'h0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_legal) begin
            next_state = DONE;
            load_en    = 1'b1;
          end else if (req_shift) begin
            if (shamt_sat == '0) begin
              next_state = DONE;
              load_en    = 1'b1;
              load_val   = req_a;
            end else begin
              next_state = SHIFT;
            end
          end else begin
            next_state = EXEC;
          end
        end
      end
      EXEC: begin
        alu_instruction = op_q;
        next_state      = DONE;
        load_en         = 1'b1;
        load_val        = alu_result;
      end
      SHIFT: begin
        alu_instruction = op_q;
        if (cnt == CNT_W'(1)) begin
          next_state = DONE;
          load_en    = 1'b1;
          load_val   = alu_result;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Flags are registered alongside the result so they hold their reset value of 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= OP_MOVE;
      acc         <= 16'h0000;
      b_q         <= 16'h0000;
      cnt         <= '0;
      rsp_data    <= 16'h0000;
      rsp_zero    <= 1'b0;
      rsp_neg     <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= req_op;
        acc         <= req_a;
        b_q         <= req_b;
        cnt         <= shamt_sat;
        rsp_illegal <= !req_legal;
        rsp_write   <= req_legal && (req_op != OP_TEST);
      end
      if (state == SHIFT) begin
        acc <= alu_result;
        cnt <= cnt - CNT_W'(1);
      end
      if (load_en) begin
        rsp_data <= load_val;
        rsp_zero <= (load_val == 16'h0000);
        rsp_neg  <= load_val[15];
      end
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller in front of the combinational 16-bit ALU.
- Accepts one operation at a time over a valid/ready request port and drives the ALU's instruction and operand inputs.
- Iterates the ALU's fixed 1-bit SHIFTR/SHIFTL to perform shifts by an arbitrary amount taken from operand B.
- Returns the result and flags over a valid/ready response port to the register-file/writeback stage.

Parameters:
- MAX_SHIFT, 16, iteration ceiling; shift amounts above this saturate to MAX_SHIFT (result is 0).
- SHAMT_BITS, 5, number of low bits of req_b used as the shift amount.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  6  opcode: MOVE=3, NOT=4, AND=5, OR=6, SHIFTR=7, SHIFTL=8, ADD=9, SUB=10, TEST=11.
- req_a  input  16  operand A.
- req_b  input  16  operand B; for shifts, bits [SHAMT_BITS-1:0] are the amount.
- alu_instruction  output  6  to ALU instruction input.
- alu_a  output  16  to ALU data_in_A.
- alu_b  output  16  to ALU data_in_B.
- alu_result  input  16  from ALU data_out.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  16  result word.
- rsp_zero  output  1  rsp_data == 0.
- rsp_neg  output  1  rsp_data[15].
- rsp_write  output  1  result is to be written back; 0 for TEST and for illegal opcodes.
- rsp_illegal  output  1  opcode outside 3..11.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_neg=0, rsp_write=0, rsp_illegal=0, alu_instruction=3, alu_a=0, alu_b=0.
- Reset mid-operation discards the in-flight operation; no response is produced for it.
- States: IDLE, EXEC, SHIFT, DONE.
- req_ready=1 only in IDLE.
- IDLE:
  - Handshake is req_valid & req_ready.
  - On handshake, capture op, A, B; acc<=req_a.
  - Shift count: cnt<=min(req_b[SHAMT_BITS-1:0], MAX_SHIFT).
  - Legal non-shift opcode -> EXEC.
  - Shift opcode with cnt>0 -> SHIFT.
  - Shift opcode with cnt=0 -> DONE with rsp_data=req_a.
  - Illegal opcode -> DONE with rsp_data=0, rsp_illegal=1, rsp_write=0.
- EXEC (exactly 1 cycle):
  - Drive alu_instruction=op, alu_a=acc, alu_b=captured B.
  - Register alu_result into rsp_data -> DONE.
- SHIFT:
  - Drive alu_instruction=op, alu_a=acc.
  - Each cycle: acc<=alu_result, cnt<=cnt-1.
  - When cnt==1, register alu_result into rsp_data -> DONE.
- Outside EXEC/SHIFT: alu_instruction=3 (MOVE), alu_a=acc, alu_b=captured B.
- DONE:
  - rsp_valid=1; rsp_data and all flags held stable until rsp_valid & rsp_ready, then -> IDLE.
  - Backpressure may stall indefinitely.
- Flags are computed from the registered rsp_data: zero = (rsp_data==0), neg = rsp_data[15].
- rsp_write=1 for legal opcodes other than TEST.
- TEST: rsp_data is the ALU's A-B result; rsp_write=0.
- Latency, handshake at edge T:
  - Legal non-shift: rsp_valid from T+2.
  - Shift by N (1..MAX_SHIFT): rsp_valid from T+1+N.
  - Shift by 0 or illegal opcode: rsp_valid from T+1.
- No new request is accepted in the cycle the response handshakes; req_ready rises the following cycle (one op in flight maximum).
- Arithmetic is mod 2^16; no carry or overflow output.
- Shift amounts ≥16: with MAX_SHIFT=16 the result is 0 after 16 iterations.
- req_b bits above SHAMT_BITS are ignored for shifts.

Test Plan:
- Reset, then ADD a=0x7FFF b=0x0001 -> rsp_valid at T+2, rsp_data=0x8000, neg=1, zero=0, write=1.
- SUB a=5 b=5, with rsp_ready held low 4 cycles -> rsp_data=0, zero=1, all outputs stable until rsp_ready, req_ready=0 throughout.
- SHIFTL a=0x0001 b=15 -> 15 SHIFT cycles, rsp_data=0x8000 at T+16; SHIFTR a=0xFFFF b=31 -> saturates to 16, rsp_data=0, zero=1.
- SHIFTR a=0x1234 b=0 -> rsp_valid at T+1, rsp_data=0x1234; TEST a=3 b=4 -> rsp_data=0xFFFF, write=0.
- Opcode 12 and opcode 0 -> rsp_illegal=1, rsp_write=0, rsp_data=0, alu_instruction stays 3.
- Assert reset_n low during cycle 5 of a 10-step shift -> immediately IDLE, rsp_valid=0, req_ready=1; next MOVE b=0xBEEF returns 0xBEEF.
